// File: rtl/switch_debounce_fifo_if.sv
// switch_debounce_fifo_if
//   Processor-side bus bundle for the switch debounce peripheral.
//   The shared tristate data bus (DBUS) stays a plain inout port on the
//   device, because it is resolved between several drivers on the board.
// Signals:
//   ABUS  address bus (master -> slave)
//   WE    write enable, 1 = write, 0 = read (master -> slave)
//   INTR  level interrupt request (slave -> master)
interface switch_debounce_fifo_if #(
  parameter int BITS = 32
);
  logic [BITS-1:0] ABUS;
  logic            WE;
  logic            INTR;

  modport master (output ABUS, output WE, input INTR);
  modport slave  (input ABUS, input WE, output INTR);
endinterface

// File: rtl/switch_debounce_fifo.sv
// switch_debounce_fifo
//   Memory-mapped switch/key peripheral. NCH raw switch inputs are
//   synchronized, debounced on a 1 ms sample tick with a run-time period,
//   and every change of the debounced vector is queued in an event FIFO.
//   A level interrupt is raised while events are pending and enabled.
//   Register map (byte offsets from BASE):
//     +0  DATA  debounced vector (read-only)
//     +4  CTRL  bit0 Ready, bit1 Overrun (write 0 clears), bit4 IE,
//               bits 11:8 FIFO count (saturating at 15)
//     +8  CFG   bits 7:0 debounce period in ms (0 behaves as 1)
//     +12 EVT   read pops {changed mask << 16, new vector}
// Ports:
//   CLK    system clock
//   RST    asynchronous active-high reset
//   INPUT  raw asynchronous switch levels
//   DBUS   bidirectional data bus, driven only while this block is read
//   bus    ABUS / WE / INTR bundle (slave side)
module switch_debounce_fifo #(
  parameter int              BITS         = 32,
  parameter int              NCH          = 10,
  parameter logic [BITS-1:0] BASE         = 32'hFFFFF090,
  parameter int              TICKS_PER_MS = 96000,
  parameter int              FIFO_DEPTH   = 8,
  parameter int              DB_DEFAULT   = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       INPUT,
  inout  wire  [BITS-1:0]      DBUS,
  switch_debounce_fifo_if.slave bus
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * NCH;

  localparam logic [BITS-1:0] ADDR_DATA = BASE;
  localparam logic [BITS-1:0] ADDR_CTRL = BASE + BITS'(4);
  localparam logic [BITS-1:0] ADDR_CFG  = BASE + BITS'(8);
  localparam logic [BITS-1:0] ADDR_EVT  = BASE + BITS'(12);

  logic [NCH-1:0] sync1_q, sync2_q;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic           tick;
  logic [NCH-1:0] db_q, db_d, flip;
  logic [7:0]     cnt_q [NCH];
  logic [7:0]     cnt_d [NCH];
  logic [7:0]     cfg_q, cfg_d, cfg_eff;
  logic           ie_q, ie_d, ovr_q, ovr_d, intr_q, intr_d;
  logic           rd_evt_q, rd_evt;
  logic [EW-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0]  fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push, do_push, do_pop, overflow, full;
  logic           wr_ctrl, wr_cfg;
  logic [BITS-1:0] wr_data, rd_data, evt_word;
  logic           rd_hit;
  logic [EW-1:0]  head;
  logic [31:0]    count_ext;
  logic [3:0]     count_sat;
  logic           unused_wr_bits;

  assign wr_data        = DBUS;
  assign unused_wr_bits = ^wr_data[BITS-1:8];
  assign wr_ctrl        = bus.WE && (bus.ABUS == ADDR_CTRL);
  assign wr_cfg         = bus.WE && (bus.ABUS == ADDR_CFG);
  assign rd_evt         = !bus.WE && (bus.ABUS == ADDR_EVT);
  assign tick           = (tick_cnt_q == TICK_LAST);
  assign cfg_eff        = (cfg_q == 8'd0) ? 8'd1 : cfg_q;
  assign head           = fifo_mem_q[rd_ptr_q];
  assign count_ext      = 32'(count_q);
  assign count_sat      = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign bus.INTR       = intr_q;
  assign DBUS           = rd_hit ? rd_data : 'z;

  // Debounce: on each tick a channel that disagrees with its debounced
  // level counts up; reaching the period (compared as >= so a lowered CFG
  // takes effect immediately) flips the bit. Agreement clears the count.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    cnt_d      = cnt_q;
    flip       = '0;
    if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (({1'b0, cnt_q[i]} + 9'd1) >= {1'b0, cfg_eff}) begin
          flip[i]  = 1'b1;
          cnt_d[i] = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
    db_d = db_q ^ flip;
  end

  // Event FIFO. A pop fires only on the first cycle of an EVT read; when
  // full, a simultaneous pop frees the slot so the push still lands.
  always_comb begin
    push       = |flip;
    do_pop     = rd_evt && !rd_evt_q && (count_q != '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    do_push    = push && (!full || do_pop);
    overflow   = push && !do_push;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) begin
      fifo_mem_d[wr_ptr_q] = {flip, db_d};
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control/config registers. A new overflow wins over a clearing write
  // in the same cycle so the loss is never silently hidden.
  always_comb begin
    ie_d  = ie_q;
    ovr_d = ovr_q;
    cfg_d = cfg_q;
    if (wr_ctrl) begin
      ie_d = wr_data[4];
      if (!wr_data[1]) begin
        ovr_d = 1'b0;
      end
    end
    if (overflow) begin
      ovr_d = 1'b1;
    end
    if (wr_cfg) begin
      cfg_d = wr_data[7:0];
    end
    intr_d = (count_q != '0) && ie_q;
  end

  if (NCH <= 16) begin : g_evt_mask
    always_comb begin
      evt_word                = '0;
      evt_word[NCH-1:0]       = head[NCH-1:0];
      evt_word[NCH+15:16]     = head[EW-1:NCH];
    end
  end else begin : g_evt_vec
    always_comb begin
      evt_word          = '0;
      evt_word[NCH-1:0] = head[NCH-1:0];
    end
  end

  // Read mux; unmapped addresses leave the bus undriven.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (!bus.WE) begin
      case (bus.ABUS)
        ADDR_DATA: begin
          rd_hit            = 1'b1;
          rd_data[NCH-1:0]  = db_q;
        end
        ADDR_CTRL: begin
          rd_hit        = 1'b1;
          rd_data[0]    = (count_q != '0);
          rd_data[1]    = ovr_q;
          rd_data[4]    = ie_q;
          rd_data[11:8] = count_sat;
        end
        ADDR_CFG: begin
          rd_hit       = 1'b1;
          rd_data[7:0] = cfg_q;
        end
        ADDR_EVT: begin
          rd_hit  = 1'b1;
          rd_data = (count_q != '0) ? evt_word : '0;
        end
        default: begin
          rd_hit = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      db_q       <= '0;
      cnt_q      <= '{default: '0};
      cfg_q      <= 8'(DB_DEFAULT);
      ie_q       <= 1'b0;
      ovr_q      <= 1'b0;
      intr_q     <= 1'b0;
      rd_evt_q   <= 1'b0;
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync1_q    <= INPUT;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      ie_q       <= ie_d;
      ovr_q      <= ovr_d;
      intr_q     <= intr_d;
      rd_evt_q   <= rd_evt;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_switch_debounce_fifo.sv
// tb_switch_debounce_fifo
//   Directed bench for switch_debounce_fifo with a 10-cycle sample tick.
//   Register accesses after reset come from a vector table; the
//   debounce, interrupt, overflow, multi-cycle read and reset scenarios
//   are hand-written sequences aligned to the known tick phase.
module tb_switch_debounce_fifo;

  localparam logic [31:0] BASE  = 32'hFFFFF090;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_CTRL = BASE + 32'd4;
  localparam logic [31:0] A_CFG  = BASE + 32'd8;
  localparam logic [31:0] A_EVT  = BASE + 32'd12;
  localparam logic [31:0] A_IDLE = 32'h0000_0000;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic [9:0]  INPUT;
  wire  [31:0] DBUS;
  logic        drv_en;
  logic [31:0] drv_data;
  int          errors;
  int          checks;
  int          cyc;

  switch_debounce_fifo_if #(.BITS(32)) bus_if ();

  assign DBUS = drv_en ? drv_data : 'z;

  switch_debounce_fifo #(
    .BITS(32), .NCH(10), .BASE(BASE), .TICKS_PER_MS(10),
    .FIFO_DEPTH(8), .DB_DEFAULT(10)
  ) dut (
    .CLK(CLK), .RST(RST), .INPUT(INPUT), .DBUS(DBUS), .bus(bus_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Posedges since reset release; the sample tick lands on multiples of 10.
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] val);
    bus_if.ABUS = addr;
    bus_if.WE   = 1'b0;
    drv_en      = 1'b0;
    #1;
    val         = DBUS;
    bus_if.ABUS = A_IDLE;
  endtask

  task automatic check_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    peek(addr, v);
    checkOutput(name, v, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.ABUS = addr;
    bus_if.WE   = 1'b1;
    drv_data    = data;
    drv_en      = 1'b1;
    @(posedge CLK);
    #1;
    bus_if.WE   = 1'b0;
    drv_en      = 1'b0;
    bus_if.ABUS = A_IDLE;
  endtask

  // EVT read held for ncyc clocks, followed by one idle clock.
  task automatic read_evt(input int ncyc, output logic [31:0] val);
    bus_if.ABUS = A_EVT;
    bus_if.WE   = 1'b0;
    drv_en      = 1'b0;
    #1;
    val = DBUS;
    repeat (ncyc) @(posedge CLK);
    #1;
    bus_if.ABUS = A_IDLE;
    @(posedge CLK);
    #1;
  endtask

  task automatic align_tick();
    while (cyc % 10 != 0) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] r;
    if (v.wr) begin
      bus_write(v.addr, v.data);
    end else begin
      peek(v.addr, r);
      checkOutput($sformatf("vec[%0d]", idx), r, v.exp);
    end
  endtask

  initial begin
    vec_t        vecs [14];
    logic [31:0] r;
    logic [9:0]  vec;
    logic [31:0] exp_q [$];
    logic [31:0] e1, e2;
    int          chans [9];

    errors = 0;
    checks = 0;
    RST = 1'b1;
    INPUT = '0;
    bus_if.ABUS = A_IDLE;
    bus_if.WE = 1'b0;
    drv_en = 1'b0;
    drv_data = '0;

    vecs[0]  = '{1'b0, A_DATA, 32'h0,       32'h0};
    vecs[1]  = '{1'b0, A_CTRL, 32'h0,       32'h0};
    vecs[2]  = '{1'b0, A_CFG,  32'h0,       32'd10};
    vecs[3]  = '{1'b0, A_EVT,  32'h0,       32'h0};
    vecs[4]  = '{1'b1, A_CFG,  32'h1FF,     32'h0};
    vecs[5]  = '{1'b0, A_CFG,  32'h0,       32'hFF};
    vecs[6]  = '{1'b1, A_CFG,  32'h3,       32'h0};
    vecs[7]  = '{1'b0, A_CFG,  32'h0,       32'h3};
    vecs[8]  = '{1'b1, A_DATA, 32'h3FF,     32'h0};
    vecs[9]  = '{1'b0, A_DATA, 32'h0,       32'h0};
    vecs[10] = '{1'b1, A_CTRL, 32'h12,      32'h0};
    vecs[11] = '{1'b0, A_CTRL, 32'h0,       32'h10};
    vecs[12] = '{1'b1, A_CTRL, 32'h0,       32'h0};
    vecs[13] = '{1'b0, A_CTRL, 32'h0,       32'h0};

    #22;
    checkOutput("reset_intr", {31'h0, bus_if.INTR}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // First change on channel 0: commits on the third tick.
    align_tick();
    INPUT[0] = 1'b1;
    wait_cycles(29);
    check_reg("db_before_3rd_tick", A_DATA, 32'h0);
    wait_cycles(1);
    check_reg("db_after_3rd_tick", A_DATA, 32'h1);
    check_reg("ctrl_one_entry", A_CTRL, 32'h101);
    checkOutput("intr_ie_off", {31'h0, bus_if.INTR}, 32'h0);
    read_evt(1, r);
    checkOutput("evt_first", r, 32'h0001_0001);
    check_reg("ctrl_after_pop", A_CTRL, 32'h0);

    // Glitch on channel 2 spanning only two ticks.
    align_tick();
    INPUT[2] = 1'b1;
    wait_cycles(25);
    INPUT[2] = 1'b0;
    wait_cycles(20);
    check_reg("glitch_data", A_DATA, 32'h1);
    check_reg("glitch_ctrl", A_CTRL, 32'h0);
    checkOutput("glitch_intr", {31'h0, bus_if.INTR}, 32'h0);

    // Interrupt path.
    bus_write(A_CTRL, 32'h10);
    align_tick();
    INPUT[4] = 1'b1;
    wait_cycles(30);
    checkOutput("intr_same_edge", {31'h0, bus_if.INTR}, 32'h0);
    check_reg("ctrl_ie_ready", A_CTRL, 32'h111);
    wait_cycles(1);
    checkOutput("intr_next_edge", {31'h0, bus_if.INTR}, 32'h1);
    read_evt(1, r);
    checkOutput("evt_irq", r, 32'h0010_0011);
    checkOutput("intr_fall", {31'h0, bus_if.INTR}, 32'h0);
    check_reg("ctrl_ready_clear", A_CTRL, 32'h10);
    read_evt(1, r);
    checkOutput("evt_empty", r, 32'h0);

    // Overflow: nine changes, the ninth is dropped.
    vec = 10'h011;
    chans = '{5, 6, 7, 8, 9, 5, 6, 7, 8};
    for (int k = 0; k < 9; k++) begin
      align_tick();
      INPUT[chans[k]] = ~INPUT[chans[k]];
      vec[chans[k]] = ~vec[chans[k]];
      if (k < 8) exp_q.push_back(({22'h0, 10'h1 << chans[k]} << 16) | {22'h0, vec});
      wait_cycles(30);
    end
    check_reg("ovf_ctrl", A_CTRL, 32'h813);
    check_reg("ovf_data", A_DATA, {22'h0, vec});
    checkOutput("ovf_intr", {31'h0, bus_if.INTR}, 32'h1);
    bus_write(A_CTRL, 32'h12);
    check_reg("ovr_write1_ignored", A_CTRL, 32'h813);
    bus_write(A_CTRL, 32'h10);
    check_reg("ovr_cleared", A_CTRL, 32'h811);
    bus_write(A_CTRL, 32'h12);
    check_reg("ovr_stays_clear", A_CTRL, 32'h811);
    for (int k = 0; k < 8; k++) begin
      read_evt(1, r);
      checkOutput($sformatf("ovf_entry%0d", k), r, exp_q[k]);
    end
    check_reg("ovf_drained", A_CTRL, 32'h10);
    checkOutput("ovf_intr_off", {31'h0, bus_if.INTR}, 32'h0);

    // Simultaneous rise of channels 1 and 3, then a change on channel 6.
    align_tick();
    INPUT[1] = 1'b1;
    INPUT[3] = 1'b1;
    vec = vec ^ 10'h00A;
    e1 = (32'h000A << 16) | {22'h0, vec};
    wait_cycles(30);
    INPUT[6] = 1'b1;
    vec[6] = 1'b1;
    e2 = (32'h0040 << 16) | {22'h0, vec};
    wait_cycles(30);
    check_reg("two_entries", A_CTRL, 32'h211);
    read_evt(3, r);
    checkOutput("evt_simul_mask", r, e1);
    check_reg("one_pop_for_long_read", A_CTRL, 32'h111);
    read_evt(1, r);
    checkOutput("evt_after_long", r, e2);

    // Reset with three queued events.
    for (int k = 0; k < 3; k++) begin
      align_tick();
      INPUT[7 + (k % 2)] = ~INPUT[7 + (k % 2)];
      wait_cycles(30);
    end
    check_reg("three_entries", A_CTRL, 32'h311);
    INPUT = '0;
    #3;
    RST = 1'b1;
    #1;
    checkOutput("rst_intr", {31'h0, bus_if.INTR}, 32'h0);
    check_reg("rst_data", A_DATA, 32'h0);
    check_reg("rst_ctrl", A_CTRL, 32'h0);
    check_reg("rst_cfg", A_CFG, 32'd10);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_reg("post_rst_evt", A_EVT, 32'h0);

    // CFG = 0 behaves as a one-tick period.
    bus_write(A_CFG, 32'h0);
    check_reg("cfg_zero", A_CFG, 32'h0);
    align_tick();
    INPUT[0] = 1'b1;
    wait_cycles(9);
    check_reg("cfg0_before", A_DATA, 32'h0);
    wait_cycles(1);
    check_reg("cfg0_after", A_DATA, 32'h1);
    check_reg("cfg0_ctrl", A_CTRL, 32'h101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
